// File: rtl/axi_aw_w_splitter.sv
// axi_aw_w_splitter: splits a combined AW+W beat stream into independent AXI4 AW and W channels.
// Define AXI_SPLIT_W_AFTER_AW_EN to hold each burst's W beats until its AW has handshaken.
module axi_aw_w_splitter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 64,
    parameter int ID_WIDTH    = 4,
    parameter int WFIFO_DEPTH = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [ADDR_WIDTH-1:0]            in_addr,
    input  logic [ID_WIDTH-1:0]              in_id,
    input  logic [1:0]                       in_burst,
    input  logic [2:0]                       in_size,
    input  logic [7:0]                       in_len,
    input  logic [DATA_WIDTH-1:0]            in_wdata,
    input  logic [DATA_WIDTH/8-1:0]          in_wstrb,
    input  logic                             in_wlast,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [ADDR_WIDTH-1:0]            out_awaddr,
    output logic [ID_WIDTH-1:0]              out_awid,
    output logic [1:0]                       out_awburst,
    output logic [2:0]                       out_awsize,
    output logic [7:0]                       out_awlen,
    output logic                             out_awvalid,
    input  logic                             out_awready,
    output logic [DATA_WIDTH-1:0]            out_wdata,
    output logic [DATA_WIDTH/8-1:0]          out_wstrb,
    output logic                             out_wlast,
    output logic                             out_wvalid,
    input  logic                             out_wready,
    output logic [$clog2(WFIFO_DEPTH):0]     wfifo_count,
    output logic                             len_err
);
    localparam int PW = $clog2(WFIFO_DEPTH);
    localparam int SW = DATA_WIDTH / 8;
    localparam int FW = DATA_WIDTH + SW + 1;

    logic [FW-1:0]         r_mem [WFIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
    logic [PW:0]           r_count;
    logic                  r_first, r_len_err, r_awvalid;
    logic [7:0]            r_beat_cnt, r_len, r_awlen;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [ID_WIDTH-1:0]   r_awid;
    logic [1:0]            r_awburst;
    logic [2:0]            r_awsize;
    logic                  w_full, w_empty, w_aw_free, w_push, w_pop, w_aw_load, w_aw_hs, w_len_bad;
    logic [7:0]            w_exp_len;

    assign w_full    = r_count == (PW+1)'(WFIFO_DEPTH);
    assign w_empty   = r_count == '0;
    assign w_aw_free = !r_awvalid || out_awready;
    assign in_ready  = !w_full && (!r_first || w_aw_free);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_wvalid && out_wready;
    assign w_aw_load = w_push && r_first;
    assign w_aw_hs   = r_awvalid && out_awready;
    assign w_exp_len = r_first ? in_len : r_len;
    // A beat is malformed when its wlast disagrees with whether it is the final beat by length.
    assign w_len_bad = w_push && (in_wlast != (r_beat_cnt == w_exp_len));

    assign out_awaddr  = r_awaddr;
    assign out_awid    = r_awid;
    assign out_awburst = r_awburst;
    assign out_awsize  = r_awsize;
    assign out_awlen   = r_awlen;
    assign out_awvalid = r_awvalid;
    assign wfifo_count = r_count;
    assign len_err     = r_len_err;
    assign {out_wdata, out_wstrb, out_wlast} = r_mem[r_rd_ptr];

`ifdef AXI_SPLIT_W_AFTER_AW_EN
    logic [PW+1:0] r_credits;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_credits <= '0;
        else
            r_credits <= r_credits + (PW+2)'(w_aw_hs) - (PW+2)'(w_pop && out_wlast);
    end
    assign out_wvalid = !w_empty && (r_credits != '0);
`else
    assign out_wvalid = !w_empty;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_awvalid <= 1'b0;
            r_awaddr  <= '0;
            r_awid    <= '0;
            r_awburst <= '0;
            r_awsize  <= '0;
            r_awlen   <= '0;
        end else if (w_aw_load) begin
            r_awvalid <= 1'b1;
            r_awaddr  <= in_addr;
            r_awid    <= in_id;
            r_awburst <= in_burst;
            r_awsize  <= in_size;
            r_awlen   <= in_len;
        end else if (w_aw_hs) begin
            r_awvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_first    <= 1'b1;
            r_beat_cnt <= '0;
            r_len      <= '0;
            r_len_err  <= 1'b0;
        end else if (w_push) begin
            r_first    <= in_wlast;
            r_beat_cnt <= in_wlast ? 8'd0 : (r_beat_cnt == 8'hFF ? 8'hFF : r_beat_cnt + 8'd1);
            if (r_first)
                r_len <= in_len;
            if (w_len_bad)
                r_len_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= {in_wdata, in_wstrb, in_wlast};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
        end
    end
endmodule

// File: tb/tb_axi_aw_w_splitter.sv
// tb_axi_aw_w_splitter: directed scenarios plus a randomized run scored against a queue-based model.
module tb_axi_aw_w_splitter;
    localparam int DEPTH = 8;
`ifdef AXI_SPLIT_W_AFTER_AW_EN
    localparam bit W_AFTER_AW = 1'b1;
`else
    localparam bit W_AFTER_AW = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  id;
        logic [1:0]  burst;
        logic [2:0]  size;
        logic [7:0]  len;
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
        logic        first;
    } beat_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] in_addr = '0;
    logic [3:0]  in_id = '0;
    logic [1:0]  in_burst = '0;
    logic [2:0]  in_size = '0;
    logic [7:0]  in_len = '0;
    logic [63:0] in_wdata = '0;
    logic [7:0]  in_wstrb = '0;
    logic        in_wlast = 1'b0, in_valid = 1'b0, in_ready;
    logic [31:0] out_awaddr;
    logic [3:0]  out_awid;
    logic [1:0]  out_awburst;
    logic [2:0]  out_awsize;
    logic [7:0]  out_awlen;
    logic        out_awvalid, out_awready = 1'b0;
    logic [63:0] out_wdata;
    logic [7:0]  out_wstrb;
    logic        out_wlast, out_wvalid, out_wready = 1'b0;
    logic [3:0]  wfifo_count;
    logic        len_err;

    int checks = 0, failures = 0;
    int aw_hs = 0, acc = 0;
    logic [63:0] rx_q[$];

    axi_aw_w_splitter #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(4), .WFIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_addr(in_addr), .in_id(in_id), .in_burst(in_burst), .in_size(in_size), .in_len(in_len),
        .in_wdata(in_wdata), .in_wstrb(in_wstrb), .in_wlast(in_wlast), .in_valid(in_valid), .in_ready(in_ready),
        .out_awaddr(out_awaddr), .out_awid(out_awid), .out_awburst(out_awburst), .out_awsize(out_awsize),
        .out_awlen(out_awlen), .out_awvalid(out_awvalid), .out_awready(out_awready),
        .out_wdata(out_wdata), .out_wstrb(out_wstrb), .out_wlast(out_wlast), .out_wvalid(out_wvalid),
        .out_wready(out_wready), .wfifo_count(wfifo_count), .len_err(len_err)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_wlast = 1'b0;
        out_awready = 1'b0;
        out_wready = 1'b0;
        rx_q.delete();
        aw_hs = 0;
        acc = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                         input logic [63:0] d, input logic last);
        in_valid = 1'b1;
        in_addr = a;
        in_id = id;
        in_burst = 2'b01;
        in_size = 3'd3;
        in_len = len;
        in_wdata = d;
        in_wstrb = 8'hFF;
        in_wlast = last;
    endtask

    // One clock: observe the handshakes that the coming edge will complete, then advance.
    task automatic cyc();
        #1;
        if (out_wvalid && out_wready) rx_q.push_back(out_wdata);
        if (out_awvalid && out_awready) aw_hs++;
        if (in_valid && in_ready) acc++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (out_awvalid !== 1'b0) begin failures++; $display("FAIL reset_awvalid got=%b exp=0", out_awvalid); end
        checks++; if (out_awaddr !== 32'h0) begin failures++; $display("FAIL reset_awaddr got=%h exp=0", out_awaddr); end
        checks++; if (out_wvalid !== 1'b0) begin failures++; $display("FAIL reset_wvalid got=%b exp=0", out_wvalid); end
        checks++; if (wfifo_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", wfifo_count); end
        checks++; if (len_err !== 1'b0) begin failures++; $display("FAIL reset_len_err got=%b exp=0", len_err); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_single_beat();
        do_reset();
        out_awready = 1'b1;
        out_wready = 1'b1;
        drive(32'h1000, 4'd3, 8'd0, 64'hA5A5, 1'b1);
        cyc();
        in_valid = 1'b0;
        checks++; if (out_awvalid !== 1'b1) begin failures++; $display("FAIL single_awvalid got=%b exp=1", out_awvalid); end
        checks++; if (out_awaddr !== 32'h1000) begin failures++; $display("FAIL single_awaddr got=%h exp=1000", out_awaddr); end
        checks++; if (out_awid !== 4'd3) begin failures++; $display("FAIL single_awid got=%0d exp=3", out_awid); end
        checks++; if (out_wvalid !== !W_AFTER_AW) begin failures++; $display("FAIL single_wvalid got=%b exp=%b", out_wvalid, !W_AFTER_AW); end
        checks++; if (out_wdata !== 64'hA5A5 || out_wlast !== 1'b1) begin failures++; $display("FAIL single_wdata got=%h/%b exp=a5a5/1", out_wdata, out_wlast); end
        checks++; if (len_err !== 1'b0) begin failures++; $display("FAIL single_len_err got=%b exp=0", len_err); end
        repeat (3) cyc();
        checks++; if (out_awvalid !== 1'b0 || out_wvalid !== 1'b0) begin failures++; $display("FAIL single_drain got=%b/%b exp=0/0", out_awvalid, out_wvalid); end
    endtask

    task automatic test_aw_hold();
        do_reset();
        out_wready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(32'h4000, 4'd9, 8'd3, 64'(i + 1), i == 3);
            cyc();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_awvalid !== 1'b1 || out_awaddr !== 32'h4000 || out_awid !== 4'd9 || out_awlen !== 8'd3) begin
                failures++; $display("FAIL aw_hold_stable cyc=%0d got=%b/%h/%0d/%0d exp=1/4000/9/3", i, out_awvalid, out_awaddr, out_awid, out_awlen);
            end
            cyc();
        end
        checks++; if (rx_q.size() !== (W_AFTER_AW ? 0 : 4)) begin failures++; $display("FAIL aw_hold_w_lead got=%0d exp=%0d", rx_q.size(), W_AFTER_AW ? 0 : 4); end
        out_awready = 1'b1;
        repeat (8) cyc();
        checks++; if (aw_hs !== 1 || out_awvalid !== 1'b0) begin failures++; $display("FAIL aw_hold_hs got=%0d/%b exp=1/0", aw_hs, out_awvalid); end
        checks++; if (rx_q.size() !== 4) begin failures++; $display("FAIL aw_hold_wcount got=%0d exp=4", rx_q.size()); end
        for (int i = 0; i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== 64'(i + 1)) begin failures++; $display("FAIL aw_hold_order idx=%0d got=%h exp=%h", i, rx_q[i], i + 1); end
        end
    endtask

    task automatic test_fifo_full();
        do_reset();
        out_awready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(32'h6000, 4'd1, 8'd8, 64'(100 + i), 1'b0);
            cyc();
        end
        drive(32'h6000, 4'd1, 8'd8, 64'd108, 1'b1);
        #1;
        checks++; if (wfifo_count !== 4'd8) begin failures++; $display("FAIL full_count got=%0d exp=8", wfifo_count); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
        cyc();
        checks++; if (acc !== 8) begin failures++; $display("FAIL full_stall got=%0d exp=8", acc); end
        out_wready = 1'b1;
        cyc();
        out_wready = 1'b0;
        cyc();
        in_valid = 1'b0;
        checks++; if (acc !== 9 || wfifo_count !== 4'd8) begin failures++; $display("FAIL full_accept9 got=%0d/%0d exp=9/8", acc, wfifo_count); end
        out_wready = 1'b1;
        repeat (12) cyc();
        checks++; if (rx_q.size() !== 9 || wfifo_count !== 4'd0) begin failures++; $display("FAIL full_drain got=%0d/%0d exp=9/0", rx_q.size(), wfifo_count); end
        for (int i = 0; i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== 64'(100 + i)) begin failures++; $display("FAIL full_order idx=%0d got=%0d exp=%0d", i, rx_q[i], 100 + i); end
        end
        checks++; if (len_err !== 1'b0) begin failures++; $display("FAIL full_len_err got=%b exp=0", len_err); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_wready = 1'b1;
        drive(32'h2000, 4'd2, 8'd1, 64'hA0, 1'b0);
        cyc();
        drive(32'h2000, 4'd2, 8'd1, 64'hA1, 1'b1);
        cyc();
        drive(32'h3000, 4'd5, 8'd0, 64'hB0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_stall cyc=%0d got=%b exp=0", i, in_ready); end
            cyc();
        end
        checks++; if (acc !== 2 || out_awaddr !== 32'h2000) begin failures++; $display("FAIL b2b_held got=%0d/%h exp=2/2000", acc, out_awaddr); end
        out_awready = 1'b1;
        cyc();
        in_valid = 1'b0;
        checks++; if (out_awvalid !== 1'b1 || out_awaddr !== 32'h3000 || out_awid !== 4'd5) begin
            failures++; $display("FAIL b2b_no_bubble got=%b/%h/%0d exp=1/3000/5", out_awvalid, out_awaddr, out_awid);
        end
        checks++; if (aw_hs !== 1 || acc !== 3) begin failures++; $display("FAIL b2b_hs got=%0d/%0d exp=1/3", aw_hs, acc); end
        cyc();
        checks++; if (aw_hs !== 2 || out_awvalid !== 1'b0) begin failures++; $display("FAIL b2b_second_hs got=%0d/%b exp=2/0", aw_hs, out_awvalid); end
    endtask

    task automatic test_len_err();
        do_reset();
        out_awready = 1'b1;
        out_wready = 1'b1;
        drive(32'h5000, 4'd1, 8'd3, 64'h11, 1'b0);
        cyc();
        checks++; if (len_err !== 1'b0) begin failures++; $display("FAIL len_err_early got=%b exp=0", len_err); end
        drive(32'h5000, 4'd1, 8'd3, 64'h22, 1'b1);
        cyc();
        in_valid = 1'b0;
        checks++; if (len_err !== 1'b1) begin failures++; $display("FAIL len_err_set got=%b exp=1", len_err); end
        drive(32'h5100, 4'd1, 8'd0, 64'h33, 1'b1);
        cyc();
        in_valid = 1'b0;
        repeat (4) cyc();
        checks++; if (len_err !== 1'b1) begin failures++; $display("FAIL len_err_sticky got=%b exp=1", len_err); end
        checks++; if (rx_q.size() !== 3) begin failures++; $display("FAIL len_err_fwd_count got=%0d exp=3", rx_q.size()); end
        else begin
            checks++; if (rx_q[0] !== 64'h11 || rx_q[1] !== 64'h22 || rx_q[2] !== 64'h33) begin
                failures++; $display("FAIL len_err_fwd got=%h,%h,%h exp=11,22,33", rx_q[0], rx_q[1], rx_q[2]);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        drive(32'h7000, 4'd4, 8'd3, 64'h1, 1'b0);
        cyc();
        drive(32'h7000, 4'd4, 8'd3, 64'h2, 1'b0);
        cyc();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (out_awvalid !== 1'b0 || out_wvalid !== 1'b0 || wfifo_count !== 4'd0) begin
            failures++; $display("FAIL rst_mid_async got=%b/%b/%0d exp=0/0/0", out_awvalid, out_wvalid, wfifo_count);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_awready = 1'b1;
        out_wready = 1'b1;
        drive(32'h8000, 4'd6, 8'd0, 64'h77, 1'b1);
        cyc();
        in_valid = 1'b0;
        checks++; if (out_awvalid !== 1'b1 || out_awaddr !== 32'h8000 || out_awid !== 4'd6) begin
            failures++; $display("FAIL rst_mid_new_first got=%b/%h/%0d exp=1/8000/6", out_awvalid, out_awaddr, out_awid);
        end
        checks++; if (len_err !== 1'b0 || wfifo_count !== 4'd1) begin failures++; $display("FAIL rst_mid_state got=%b/%0d exp=0/1", len_err, wfifo_count); end
    endtask

    task automatic test_random();
        beat_t beats[$], aw_exp[$], w_exp[$];
        beat_t x, e;
        int len, bi, cnt, aw_out, aw_done, w_done, n;
        logic [31:0] a;
        logic [3:0] id;
        logic [1:0] bt;
        logic [2:0] sz;
        logic m_first, exp_ready, exp_wv, push, pop, awhs;
        do_reset();
        for (int b = 0; b < 40; b++) begin
            len = $urandom_range(0, 10);
            a = $urandom;
            id = 4'($urandom);
            bt = 2'($urandom);
            sz = 3'($urandom);
            for (int k = 0; k <= len; k++) begin
                x.addr = a; x.id = id; x.burst = bt; x.size = sz; x.len = 8'(len);
                x.data = {$urandom, $urandom}; x.strb = 8'($urandom);
                x.last = (k == len); x.first = (k == 0);
                beats.push_back(x);
                w_exp.push_back(x);
                if (k == 0) aw_exp.push_back(x);
            end
        end
        bi = 0; cnt = 0; aw_out = 0; aw_done = 0; w_done = 0; n = 0;
        while (n < 6000 && (bi < beats.size() || w_exp.size() != 0 || aw_exp.size() != 0)) begin
            in_valid = bi < beats.size() && $urandom_range(0, 3) != 0;
            if (bi < beats.size()) begin
                e = beats[bi];
                in_addr = e.first ? e.addr : $urandom;
                in_id = e.first ? e.id : 4'($urandom);
                in_burst = e.first ? e.burst : 2'($urandom);
                in_size = e.first ? e.size : 3'($urandom);
                in_len = e.first ? e.len : 8'($urandom);
                in_wdata = e.data;
                in_wstrb = e.strb;
                in_wlast = e.last;
            end
            out_awready = $urandom_range(0, 2) == 0;
            out_wready = 1'($urandom_range(0, 1));
            #1;
            m_first = bi < beats.size() ? beats[bi].first : 1'b1;
            exp_ready = cnt < DEPTH && (!m_first || aw_out == 0 || out_awready);
            exp_wv = cnt != 0 && (!W_AFTER_AW || aw_done > w_done);
            checks++; if (in_ready !== exp_ready) begin failures++; $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", n, in_ready, exp_ready); end
            checks++; if (wfifo_count !== 4'(cnt)) begin failures++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", n, wfifo_count, cnt); end
            checks++; if (out_wvalid !== exp_wv) begin failures++; $display("FAIL rand_wvalid cyc=%0d got=%b exp=%b", n, out_wvalid, exp_wv); end
            checks++; if (out_awvalid !== (aw_out != 0)) begin failures++; $display("FAIL rand_awvalid cyc=%0d got=%b exp=%b", n, out_awvalid, aw_out != 0); end
            awhs = out_awvalid && out_awready;
            pop = out_wvalid && out_wready;
            push = in_valid && in_ready;
            if (awhs) begin
                checks++;
                if (aw_exp.size() == 0) begin failures++; $display("FAIL rand_aw_extra cyc=%0d got=%h exp=none", n, out_awaddr); end
                else begin
                    e = aw_exp.pop_front();
                    if ({out_awaddr, out_awid, out_awburst, out_awsize, out_awlen} !== {e.addr, e.id, e.burst, e.size, e.len}) begin
                        failures++; $display("FAIL rand_aw cyc=%0d got=%h/%0d/%0d/%0d/%0d exp=%h/%0d/%0d/%0d/%0d", n,
                            out_awaddr, out_awid, out_awburst, out_awsize, out_awlen, e.addr, e.id, e.burst, e.size, e.len);
                    end
                end
                aw_done++;
            end
            if (pop) begin
                checks++;
                if (w_exp.size() == 0) begin failures++; $display("FAIL rand_w_extra cyc=%0d got=%h exp=none", n, out_wdata); end
                else begin
                    e = w_exp.pop_front();
                    if ({out_wdata, out_wstrb, out_wlast} !== {e.data, e.strb, e.last}) begin
                        failures++; $display("FAIL rand_w cyc=%0d got=%h/%h/%b exp=%h/%h/%b", n, out_wdata, out_wstrb, out_wlast, e.data, e.strb, e.last);
                    end
                end
                if (out_wlast) w_done++;
            end
            aw_out = aw_out - int'(awhs);
            if (push) begin
                if (beats[bi].first) aw_out++;
                bi++;
            end
            cnt = cnt + int'(push) - int'(pop);
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        checks++; if (bi != beats.size() || w_exp.size() != 0 || aw_exp.size() != 0) begin
            failures++; $display("FAIL rand_timeout got=beats%0d/w%0d/aw%0d exp=%0d/0/0", bi, w_exp.size(), aw_exp.size(), beats.size());
        end
        checks++; if (len_err !== 1'b0) begin failures++; $display("FAIL rand_len_err got=%b exp=0", len_err); end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_aw_hold();
        test_fifo_full();
        test_back_to_back();
        test_len_err();
        test_reset_mid_burst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axi_aw_w_splitter.md
Name: axi_aw_w_splitter

Overview:
- Write-side splitter that converts one combined write-request stream into independent AXI4 AW and W channels.
- Each input beat carries W data. The first beat of each burst also carries the AW fields.
- Sits between the cache write-back path and the AXI master port. It is the inverse of the AW/W merger.
- Buffers W beats in a FIFO and holds one AW in a register, so AW and W drain to the interconnect independently.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 64, data width (multiple of 8)
ID_WIDTH, 4, AXI ID width
WFIFO_DEPTH, 8, W beat FIFO depth (power of 2, >=2)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_addr  input  ADDR_WIDTH  burst address (sampled on first beat only)
in_id  input  ID_WIDTH  burst ID (first beat)
in_burst  input  2  burst type (first beat)
in_size  input  3  beat size (first beat)
in_len  input  8  beats-1 (first beat)
in_wdata  input  DATA_WIDTH  beat data
in_wstrb  input  DATA_WIDTH/8  byte strobes
in_wlast  input  1  last beat of burst
in_valid  input  1  beat valid
in_ready  output  1  beat accepted when in_valid && in_ready
out_awaddr/out_awid/out_awburst/out_awsize/out_awlen  output  ADDR_WIDTH/ID_WIDTH/2/3/8  registered AW fields
out_awvalid  output  1  AW valid
out_awready  input  1  AW ready
out_wdata  output  DATA_WIDTH  W data from FIFO head
out_wstrb  output  DATA_WIDTH/8  W strobes from FIFO head
out_wlast  output  1  W last from FIFO head
out_wvalid  output  1  W valid
out_wready  input  1  W ready
wfifo_count  output  $clog2(WFIFO_DEPTH)+1  W FIFO occupancy
len_err  output  1  sticky burst-length mismatch flag

Behaviour:
- Reset: clk is the clock; rst_n is the asynchronous active-low reset.
- Reset values: out_awvalid=0, AW fields=0, out_wvalid=0, FIFO empty, wfifo_count=0, len_err=0, first=1, beat_cnt=0.
- Out of reset, in_ready=1.
- first flag: 1 means the next accepted beat starts a burst. It is cleared on an accepted beat with in_wlast=0 and set on an accepted beat with in_wlast=1.
- aw_free = !out_awvalid || out_awready.
- in_ready = !wfifo_full && (!first || aw_free). This is combinational and does not depend on in_valid.
- Accepted first beat:
  - AW register loads in_addr/in_id/in_burst/in_size/in_len and out_awvalid=1 on the next cycle.
  - len_reg loads in_len.
  - A load in the same cycle as an AW handshake is allowed: the new AW replaces the old one with no bubble.
- AW handshake (out_awvalid && out_awready) with no new load clears out_awvalid.
- Once asserted, AW fields stay stable until the handshake completes.
- Every accepted beat pushes {wdata, wstrb, wlast} into the W FIFO. Push-to-out_wvalid latency is 1 cycle; no combinational path from in_* to out_w*.
- FIFO rules:
  - out_wvalid = !empty.
  - Pop on out_wvalid && out_wready.
  - Simultaneous push and pop when full is not possible, because in_ready=0 when full.
  - Simultaneous push and pop at any other level leaves the count unchanged.
  - Pointers wrap modulo WFIFO_DEPTH.
- beat_cnt:
  - Counts accepted beats within the burst.
  - Resets to 0 on an accepted in_wlast.
  - Otherwise increments, saturating at 255.
- len_err:
  - Set if an accepted beat has in_wlast=1 and beat_cnt != len_reg (for a first beat, compare against in_len).
  - Also set if beat_cnt == len_reg and in_wlast=0.
  - Sticky until reset. Data is still forwarded unchanged.
- W beats may lead their AW by up to WFIFO_DEPTH beats (AXI4-legal).
- Reset mid-burst: all state is cleared immediately; any partial burst is discarded.

Optional Feature:
- Macro: AXI_SPLIT_W_AFTER_AW_EN.
- When defined:
  - A credit counter, width $clog2(WFIFO_DEPTH)+2, increments on each AW handshake and decrements on each W handshake with out_wlast=1.
  - out_wvalid = !empty && (credits != 0).
  - If both events occur in one cycle, the count is unchanged.
  - Guarantees no W beat is presented before its burst's AW handshake, for AXI3-style slaves.
- When undefined: no counter; out_wvalid = !empty.

Test Plan:
- Single beat: in_len=0, in_wlast=1, addr=0x1000, id=3, wdata=0xA5A5, both readys=1 -> out_awvalid=1 with awaddr=0x1000, awid=3 one cycle later; out_wvalid=1 with wdata=0xA5A5, wlast=1 in the same cycle; len_err=0.
- 4-beat burst: in_len=3, data 1..4, out_wready=1, out_awready=0 for 10 cycles -> all 4 W beats drain before AW (macro off); AW holds fields stable; with macro on, W is held until the AW handshake, then beats 1..4 appear in order.
- FIFO full: WFIFO_DEPTH=8, out_wready=0, 9 continuous beats -> wfifo_count reaches 8, in_ready=0 on the 9th; releasing out_wready for 1 cycle accepts the 9th; no beat is lost or duplicated.
- Back-to-back bursts: burst A (len 1) then burst B (len 0), out_awready=0 -> B's first beat stalls (in_ready=0) until A's AW handshake; same-cycle handshake plus load shows no bubble.
- Length error: in_len=3 with in_wlast on the 2nd beat -> len_err=1 on the next cycle and stays set; data is still forwarded.
- Reset mid-burst: assert rst_n=0 after 2 of 4 beats -> out_awvalid=0, out_wvalid=0, count=0 asynchronously; after release, a new burst is accepted as a first beat.
